// File: rtl/add_sequencer_pkg.sv
// Shared types for the add sequencer: datapath widths, opcodes and FSM states.
package add_sequencer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_num_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ADD  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/add_sequencer_if.sv
// Command handshake plus register-file/adder port shared by the sequencer and its stage.
interface add_sequencer_if;
  import add_sequencer_pkg::*;

  logic     cmdValid;
  logic     cmdReady;
  op_e      cmdOp;
  reg_num_t cmdA;
  reg_num_t cmdB;
  reg_num_t cmdDst;
  data_t    cmdImm;

  reg_num_t rdNumA;
  reg_num_t rdNumB;
  data_t    sum;
  data_t    wrData;
  reg_num_t wrNum;
  logic     wrEnable;

  // Sequencer side
  modport slave (
    input  cmdValid, cmdOp, cmdA, cmdB, cmdDst, cmdImm, sum,
    output cmdReady, rdNumA, rdNumB, wrData, wrNum, wrEnable
  );

  // Command source and register-file stage side
  modport master (
    output cmdValid, cmdOp, cmdA, cmdB, cmdDst, cmdImm, sum,
    input  cmdReady, rdNumA, rdNumB, wrData, wrNum, wrEnable
  );

endinterface

// File: rtl/add_sequencer.sv
// Sequences NOP/LOAD/ADD commands against an external register file and adder.
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  add_sequencer_if.slave     bus,
  output logic               done,
  output data_t              result,
  output logic [CNT_W-1:0]   opCount,
  output logic               err
);

  state_e             state_q,    state_d;
  reg_num_t           rd_num_a_q, rd_num_a_d;
  reg_num_t           rd_num_b_q, rd_num_b_d;
  reg_num_t           wr_num_q,   wr_num_d;
  data_t              wr_data_q,  wr_data_d;
  reg_num_t           dst_q,      dst_d;
  data_t              result_q,   result_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic               err_q,      err_d;

  logic               accept_c;

  assign bus.cmdReady = (state_q == ST_IDLE) && !rst;
  assign bus.wrEnable = (state_q == ST_WB) && !rst;
  assign accept_c     = bus.cmdValid && bus.cmdReady;

  assign done    = (state_q == ST_DONE) && !rst;
  assign result  = result_q;
  assign opCount = op_count_q;
  assign err     = err_q;

  assign bus.rdNumA = rd_num_a_q;
  assign bus.rdNumB = rd_num_b_q;
  assign bus.wrNum  = wr_num_q;
  assign bus.wrData = wr_data_q;

  // Port registers are loaded on entry to the state that drives them, so they hold otherwise.
  always_comb begin
    state_d    = state_q;
    rd_num_a_d = rd_num_a_q;
    rd_num_b_d = rd_num_b_q;
    wr_num_d   = wr_num_q;
    wr_data_d  = wr_data_q;
    dst_d      = dst_q;
    result_d   = result_q;
    op_count_d = op_count_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          dst_d = bus.cmdDst;
          unique case (bus.cmdOp)
            OP_ADD: begin
              rd_num_a_d = bus.cmdA;
              rd_num_b_d = bus.cmdB;
              state_d    = ST_EXEC;
            end
            OP_LOAD: begin
              wr_num_d  = bus.cmdDst;
              wr_data_d = bus.cmdImm;
              state_d   = ST_WB;
            end
            OP_NOP: begin
              state_d = ST_DONE;
            end
            OP_RSVD: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_EXEC: begin
        // Sources are read here, a cycle before the write, so dst aliasing sees old values.
        result_d  = bus.sum;
        wr_num_d  = dst_q;
        wr_data_d = bus.sum;
        state_d   = ST_WB;
      end
      ST_WB: begin
        result_d = wr_data_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        op_count_d = op_count_q + CNT_W'(1);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_num_a_q <= '0;
      rd_num_b_q <= '0;
      wr_num_q   <= '0;
      wr_data_q  <= '0;
      dst_q      <= '0;
      result_q   <= '0;
      op_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_num_a_q <= rd_num_a_d;
      rd_num_b_q <= rd_num_b_d;
      wr_num_q   <= wr_num_d;
      wr_data_q  <= wr_data_d;
      dst_q      <= dst_d;
      result_q   <= result_d;
      op_count_q <= op_count_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer with a behavioural register file and adder.
module tb_add_sequencer;
  import add_sequencer_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             done;
  data_t            result;
  logic [CNT_W-1:0] opCount;
  logic             err;
  logic             rf_clear;
  data_t            rf [32];

  int checks = 0;
  int errors = 0;

  add_sequencer_if bus ();

  add_sequencer #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .done    (done),
    .result  (result),
    .opCount (opCount),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file plus combinational adder stage
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wrEnable) begin
      rf[bus.wrNum] <= bus.wrData;
    end
  end
  assign bus.sum = rf[bus.rdNumA] + rf[bus.rdNumB];

  // Issue one command; report write/done cycle offsets relative to the accept cycle.
  task automatic send(input op_e op, input reg_num_t a, input reg_num_t b,
                      input reg_num_t dst, input data_t imm, input bit hold,
                      output int wr_cyc, output int done_cyc,
                      output data_t wr_val, output reg_num_t wr_reg,
                      output bit ready_low_ok);
    int n;
    wr_cyc = -1; done_cyc = -1; wr_val = '0; wr_reg = '0; ready_low_ok = 1'b1;
    bus.cmdOp = op; bus.cmdA = a; bus.cmdB = b; bus.cmdDst = dst; bus.cmdImm = imm;
    bus.cmdValid = 1'b1;
    n = 0;
    while (!bus.cmdReady && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.cmdReady) begin
      bus.cmdValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) bus.cmdValid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.wrEnable) begin
        wr_cyc = c; wr_val = bus.wrData; wr_reg = bus.wrNum;
      end
      if (bus.cmdReady) ready_low_ok = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rf_clear = 1'b1;
    rst = 1'b1;
    bus.cmdValid = 1'b1;
    bus.cmdOp = OP_LOAD; bus.cmdA = '0; bus.cmdB = '0; bus.cmdDst = 5'd1; bus.cmdImm = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    rf_clear = 1'b0;
    checks++;
    if (bus.cmdReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.cmdReady); end
    checks++;
    if (bus.wrEnable !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", bus.wrEnable); end
    bus.cmdValid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmdReady !== 1'b1) begin errors++; $display("FAIL reset_ready_rel: got %b expected 1", bus.cmdReady); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b err=%b expected 0 0", done, err); end
    checks++;
    if (result !== 32'd0 || opCount !== 16'd0) begin errors++; $display("FAIL reset_vals: got result=%0d opCount=%0d expected 0 0", result, opCount); end
    checks++;
    if (bus.rdNumA !== 5'd0 || bus.rdNumB !== 5'd0 || bus.wrNum !== 5'd0 || bus.wrData !== 32'd0) begin
      errors++; $display("FAIL reset_ports: got rdA=%0d rdB=%0d wrNum=%0d wrData=%0d expected all 0",
                        bus.rdNumA, bus.rdNumB, bus.wrNum, bus.wrData);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_add();
    int w, d; data_t v; reg_num_t r; bit rl;
    send(OP_LOAD, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, w, d, v, r, rl);
    checks++;
    if (w !== 1 || d !== 2) begin errors++; $display("FAIL load1_latency: got wr=%0d done=%0d expected 1 2", w, d); end
    checks++;
    if (v !== 32'd5 || r !== 5'd1) begin errors++; $display("FAIL load1_write: got r%0d=%0d expected r1=5", r, v); end
    send(OP_LOAD, 5'd0, 5'd0, 5'd2, 32'd7, 1'b0, w, d, v, r, rl);
    checks++;
    if (w !== 1 || d !== 2 || v !== 32'd7 || r !== 5'd2) begin
      errors++; $display("FAIL load2: got wr=%0d done=%0d r%0d=%0d expected 1 2 r2=7", w, d, r, v);
    end
    checks++;
    if (result !== 32'd7) begin errors++; $display("FAIL load2_result: got %0d expected 7", result); end
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, w, d, v, r, rl);
    checks++;
    if (w !== 2 || d !== 3) begin errors++; $display("FAIL add_latency: got wr=%0d done=%0d expected 2 3", w, d); end
    checks++;
    if (rf[3] !== 32'd12 || result !== 32'd12) begin errors++; $display("FAIL add_value: got r3=%0d result=%0d expected 12 12", rf[3], result); end
    checks++;
    if (opCount !== 16'd3) begin errors++; $display("FAIL add_opcount: got %0d expected 3", opCount); end
    checks++;
    if (!rl) begin errors++; $display("FAIL add_ready_low: got ready high while busy expected low"); end
  endtask

  task automatic test_wrap();
    int w, d; data_t v; reg_num_t r; bit rl;
    send(OP_LOAD, 5'd0, 5'd0, 5'd4, 32'hFFFF_FFFF, 1'b0, w, d, v, r, rl);
    send(OP_LOAD, 5'd0, 5'd0, 5'd5, 32'd2, 1'b0, w, d, v, r, rl);
    send(OP_ADD, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, w, d, v, r, rl);
    checks++;
    if (rf[6] !== 32'd1 || v !== 32'd1 || r !== 5'd6) begin
      errors++; $display("FAIL wrap_add: got r6=%0d wr=%0d to r%0d expected 1 to r6", rf[6], v, r);
    end
    checks++;
    if (opCount !== 16'd6) begin errors++; $display("FAIL wrap_opcount: got %0d expected 6", opCount); end
  endtask

  task automatic test_self_add();
    int w, d; data_t v; reg_num_t r; bit rl;
    send(OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, w, d, v, r, rl);
    checks++;
    if (rf[1] !== 32'd10 || v !== 32'd10) begin errors++; $display("FAIL self_add1: got r1=%0d wr=%0d expected 10", rf[1], v); end
    send(OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, w, d, v, r, rl);
    checks++;
    if (rf[1] !== 32'd20 || result !== 32'd20) begin errors++; $display("FAIL self_add2: got r1=%0d result=%0d expected 20", rf[1], result); end
  endtask

  task automatic test_reserved();
    int w, d; data_t v; reg_num_t r; bit rl;
    logic [CNT_W-1:0] prev;
    prev = opCount;
    send(OP_RSVD, 5'd1, 5'd2, 5'd3, 32'd99, 1'b0, w, d, v, r, rl);
    checks++;
    if (w !== -1 || d !== 1) begin errors++; $display("FAIL rsvd_timing: got wr=%0d done=%0d expected -1 1", w, d); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rsvd_err: got %b expected 1", err); end
    checks++;
    if (opCount !== prev + 16'd1) begin errors++; $display("FAIL rsvd_opcount: got %0d expected %0d", opCount, prev + 16'd1); end
    checks++;
    if (rf[3] !== 32'd12) begin errors++; $display("FAIL rsvd_noreg: got r3=%0d expected 12", rf[3]); end
    send(OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, w, d, v, r, rl);
    checks++;
    if (d !== 1 || w !== -1) begin errors++; $display("FAIL nop_timing: got wr=%0d done=%0d expected -1 1", w, d); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_in_wb();
    int n;
    bus.cmdOp = OP_ADD; bus.cmdA = 5'd1; bus.cmdB = 5'd2; bus.cmdDst = 5'd7; bus.cmdImm = '0;
    bus.cmdValid = 1'b1;
    n = 0;
    while (!bus.cmdReady && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    checks++;
    if (bus.rdNumA !== 5'd1 || bus.rdNumB !== 5'd2 || bus.sum !== 32'd27) begin
      errors++; $display("FAIL exec_read: got rdA=%0d rdB=%0d sum=%0d expected 1 2 27", bus.rdNumA, bus.rdNumB, bus.sum);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.wrEnable !== 1'b1 || bus.wrData !== 32'd27) begin
      errors++; $display("FAIL wb_before_rst: got wren=%b data=%0d expected 1 27", bus.wrEnable, bus.wrData);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wrEnable !== 1'b0 || bus.cmdReady !== 1'b0) begin
      errors++; $display("FAIL wb_rst_comb: got wren=%b ready=%b expected 0 0", bus.wrEnable, bus.cmdReady);
    end
    @(posedge clk); #1;
    checks++;
    if (rf[7] !== 32'd0) begin errors++; $display("FAIL wb_rst_dst: got r7=%0d expected 0", rf[7]); end
    checks++;
    if (result !== 32'd0 || opCount !== 16'd0 || err !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL wb_rst_outs: got result=%0d opCount=%0d err=%b done=%b expected 0", result, opCount, err, done);
    end
    checks++;
    if (bus.wrNum !== 5'd0 || bus.wrData !== 32'd0 || bus.rdNumA !== 5'd0 || bus.rdNumB !== 5'd0) begin
      errors++; $display("FAIL wb_rst_ports: got wrNum=%0d wrData=%0d rdA=%0d rdB=%0d expected 0",
                        bus.wrNum, bus.wrData, bus.rdNumA, bus.rdNumB);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || bus.cmdReady !== 1'b1) begin
      errors++; $display("FAIL wb_rst_after: got done=%b ready=%b expected 0 1", done, bus.cmdReady);
    end
  endtask

  task automatic test_back_to_back();
    int w, d; data_t v; reg_num_t r; bit rl;
    send(OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, w, d, v, r, rl);
    checks++;
    if (d !== 1 || !rl) begin errors++; $display("FAIL b2b_nop: got done=%0d ready_low=%b expected 1 1", d, rl); end
    send(OP_LOAD, 5'd0, 5'd0, 5'd8, 32'd100, 1'b1, w, d, v, r, rl);
    checks++;
    if (d !== 2 || w !== 1 || !rl) begin errors++; $display("FAIL b2b_load: got wr=%0d done=%0d ready_low=%b expected 1 2 1", w, d, rl); end
    send(OP_ADD, 5'd8, 5'd8, 5'd9, 32'd0, 1'b1, w, d, v, r, rl);
    checks++;
    if (d !== 3 || w !== 2 || !rl) begin errors++; $display("FAIL b2b_add: got wr=%0d done=%0d ready_low=%b expected 2 3 1", w, d, rl); end
    send(OP_RSVD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, w, d, v, r, rl);
    checks++;
    if (d !== 1 || w !== -1 || !rl) begin errors++; $display("FAIL b2b_rsvd: got wr=%0d done=%0d ready_low=%b expected -1 1 1", w, d, rl); end
    bus.cmdValid = 1'b0;
    checks++;
    if (opCount !== 16'd4) begin errors++; $display("FAIL b2b_opcount: got %0d expected 4", opCount); end
    checks++;
    if (rf[9] !== 32'd200 || err !== 1'b1) begin errors++; $display("FAIL b2b_state: got r9=%0d err=%b expected 200 1", rf[9], err); end
  endtask

  initial begin
    bus.cmdValid = 1'b0;
    bus.cmdOp = OP_NOP; bus.cmdA = '0; bus.cmdB = '0; bus.cmdDst = '0; bus.cmdImm = '0;
    rst = 1'b1;
    rf_clear = 1'b1;
    test_reset();
    test_load_add();
    test_wrap();
    test_self_add();
    test_reserved();
    test_reset_in_wb();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmdValid  in  1  command present.
REQ-005 cmdReady  out  1  sequencer can accept a command this cycle.
REQ-006 cmdOp  in  2  opcode: 0 NOP, 1 LOAD, 2 ADD, 3 reserved.
REQ-007 cmdA, cmdB  in  RegNumPath (5)  source register numbers for ADD.
REQ-008 cmdDst  in  RegNumPath (5)  destination register for LOAD/ADD.
REQ-009 cmdImm  in  DataPath (32)  immediate for LOAD.
REQ-010 rdNumA, rdNumB  out  RegNumPath  read register numbers to the register-file/adder stage.
REQ-011 sum  in  DataPath  adder output (rdDataA + rdDataB, combinational) from that stage.
REQ-012 wrData, wrNum, wrEnable  out  DataPath / RegNumPath / 1  write port to the register file.
REQ-013 done  out  1  one-cycle pulse per completed command.
REQ-014 result  out  DataPath  value written by last LOAD/ADD.
REQ-015 opCount  out  CNT_W  number of completed commands, including NOP and reserved.
REQ-016 err  out  1  sticky flag: a reserved opcode was accepted.

Function
REQ-017 FSM states: IDLE, EXEC, WB, DONE; cmdReady = (state==IDLE) && !rst.
REQ-018 Accept on cmdValid && cmdReady; latch cmdOp, cmdA, cmdB, cmdDst, cmdImm into internal registers.
REQ-019 IDLE->EXEC on accepted ADD; IDLE->WB on accepted LOAD; IDLE->DONE on accepted NOP or op 3; otherwise IDLE.
REQ-020 EXEC: drive rdNumA/rdNumB from latched cmdA/cmdB; capture sum into result register at end of cycle; EXEC->WB.
REQ-021 WB: wrNum = latched cmdDst, wrData = result register (ADD) or latched cmdImm (LOAD), wrEnable = 1; result updated to written value; WB->DONE.
REQ-022 DONE: done = 1, opCount += 1 (wraps modulo 2^CNT_W); DONE->IDLE.
REQ-023 Latency from accept cycle t: ADD write at t+2, done at t+3; LOAD write at t+1, done at t+2; NOP done at t+1.
REQ-024 Throughput: next command accepted no earlier than the cycle after done.
REQ-025 wrEnable SHALL be 1 only in WB with rst low; never for NOP or op 3.
REQ-026 rdNumA/rdNumB/wrNum/wrData hold their last driven values outside EXEC/WB.
REQ-027 Op 3: no register access, completes as NOP, sets err; err remains 1 until reset.
REQ-028 ADD with cmdDst equal to cmdA or cmdB: sources read in EXEC before the write in WB (old values used).
REQ-029 Sum arithmetic is 32-bit modulo 2^32; carry discarded.
REQ-030 cmdValid deasserted or inputs changing while not ready have no effect.

Reset
REQ-031 rst high at a clock edge: state=IDLE, rdNumA=rdNumB=wrNum=0, wrData=0, result=0, done=0, opCount=0, err=0.
REQ-032 rst high mid-operation (EXEC/WB/DONE): command abandoned, no write, no done pulse, opCount unchanged except cleared.
REQ-033 While rst is high cmdReady = 0 and wrEnable = 0 combinationally.

Structure
REQ-034 Opcode encodings and FSM state encoding SHALL live in the shared types header with DataPath/RegNumPath.
REQ-035 Single module, no sub-modules; instantiated beside the RegisterFile-plus-Adder stage, driving its read/write ports and consuming its sum.

Verification
REQ-036 Reset, then LOAD r1<=5, LOAD r2<=7, ADD r3<=r1+r2 -> r3 = 12, result = 12, opCount = 3, done pulses at t+2, t+2, t+3.
REQ-037 LOAD r4<=0xFFFFFFFF, LOAD r5<=2, ADD r6<=r4+r5 -> r6 = 1 (wrap).
REQ-038 r1=5, ADD r1<=r1+r1 -> r1 = 10; repeat -> 20.
REQ-039 cmdOp=3 accepted -> no wrEnable, done at t+1, err=1 sticky, opCount+1.
REQ-040 ADD accepted, rst asserted in WB cycle -> wrEnable 0 that cycle, destination unchanged, all outputs reset values next cycle.
REQ-041 cmdValid held high continuously with 4 commands queued -> exactly one accept per command, cmdReady low between accept and done.
